dmem_arbiter: RTL and testbench

Round-robin arbiter that shares the single data-memory read/write port among the four cores. Replaces fixed core-1-first priority and per-core stall counts with registered one-transaction-per-cycle issue, per-core grant/stall handshakes and tagged read-data return. Sits between the cores' data-access ports and the memory's shared data port. The core-enable mask comes from the pause/resume state register.

---
 rtl/dmem_arbiter.sv | 112 +++++++++++
 tb/tb_dmem_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among four cores, with a
// registered command stage and a tagged read-return pipeline.
module dmem_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            core_en,
  input  logic [3:0]            req_rd,
  input  logic [3:0]            req_wr,
  input  logic [4*ADDR_W-1:0]   req_addr,
  input  logic [4*DATA_W-1:0]   req_wdata,
  output logic [3:0]            gnt_rd,
  output logic [3:0]            gnt_wr,
  output logic [3:0]            stall,
  output logic                  mem_ren,
  output logic                  mem_wen,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [3:0]            rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic [1:0]            rtag
);

  // Handshake: req_rd/req_wr are level requests held until the matching
  // gnt_rd/gnt_wr; a transfer happens in any cycle where request and grant are
  // both high, and the core must drop or change that request by the next cycle.

  logic [1:0] last;
  logic [3:0] eligible;
  logic       grant;
  logic [1:0] win;
  logic [1:0] cand;

  logic [RD_LAT:0] tag_v;
  logic [1:0]      tag_id [RD_LAT+1];

  assign eligible = reset ? 4'b0000 : (core_en & (req_rd | req_wr));

  // Walk from last+4 down to last+1 so the nearest eligible core after last wins.
  always_comb begin
    grant = 1'b0;
    win   = last;
    cand  = last;
    for (int k = 4; k >= 1; k--) begin
      cand = last + 2'(k);
      if (eligible[cand]) begin
        grant = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    gnt_rd = 4'b0000;
    gnt_wr = 4'b0000;
    if (grant) begin
      if (req_wr[win]) gnt_wr[win] = 1'b1;
      else             gnt_rd[win] = 1'b1;
    end
  end

  assign stall = eligible & ~gnt_rd & ~gnt_wr;

  always_ff @(posedge clk) begin
    if (reset) begin
      last      <= 2'd3;
      mem_ren   <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_ren <= |gnt_rd;
      mem_wen <= |gnt_wr;
      if (grant) begin
        last      <= win;
        mem_addr  <= req_addr[int'(win)*ADDR_W +: ADDR_W];
        mem_wdata <= req_wdata[int'(win)*DATA_W +: DATA_W];
      end
    end
  end

  // Stage RD_LAT lines up with mem_rdata for the read issued RD_LAT+1 cycles ago.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_v <= '0;
      for (int j = 0; j <= RD_LAT; j++) tag_id[j] <= 2'd0;
    end else begin
      tag_v     <= {tag_v[RD_LAT-1:0], |gnt_rd};
      tag_id[0] <= win;
      for (int j = 1; j <= RD_LAT; j++) tag_id[j] <= tag_id[j-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid <= 4'b0000;
      rdata  <= '0;
      rtag   <= 2'd0;
    end else if (tag_v[RD_LAT]) begin
      rvalid <= 4'b0001 << tag_id[RD_LAT];
      rdata  <= mem_rdata;
      rtag   <= tag_id[RD_LAT];
    end else begin
      rvalid <= 4'b0000;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: four instances (RD_LAT 1..4) share one stimulus and a
// reference memory; returns are matched against per-instance expected queues.
module tb_dmem_arbiter;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;
  localparam int NI     = 4;
  localparam int EW     = 32 + 2 + DATA_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset;
  logic [3:0]          core_en;
  logic [3:0]          req_rd;
  logic [3:0]          req_wr;
  logic [4*ADDR_W-1:0] req_addr;
  logic [4*DATA_W-1:0] req_wdata;

  logic [3:0]        gnt_rd_a    [NI];
  logic [3:0]        gnt_wr_a    [NI];
  logic [3:0]        stall_a     [NI];
  logic [3:0]        rvalid_a    [NI];
  logic              mem_ren_a   [NI];
  logic              mem_wen_a   [NI];
  logic [ADDR_W-1:0] mem_addr_a  [NI];
  logic [DATA_W-1:0] mem_wdata_a [NI];
  logic [DATA_W-1:0] mem_rdata_a [NI];
  logic [DATA_W-1:0] rdata_a     [NI];
  logic [1:0]        rtag_a      [NI];

  for (genvar g = 0; g < NI; g++) begin : g_lat
    logic [DATA_W-1:0] mem [2**ADDR_W] = '{default: '0};
    logic [DATA_W-1:0] rd_pipe [1:4];

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(g + 1)) dut (
      .clk       (clk),
      .reset     (reset),
      .core_en   (core_en),
      .req_rd    (req_rd),
      .req_wr    (req_wr),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .gnt_rd    (gnt_rd_a[g]),
      .gnt_wr    (gnt_wr_a[g]),
      .stall     (stall_a[g]),
      .mem_ren   (mem_ren_a[g]),
      .mem_wen   (mem_wen_a[g]),
      .mem_addr  (mem_addr_a[g]),
      .mem_wdata (mem_wdata_a[g]),
      .mem_rdata (mem_rdata_a[g]),
      .rvalid    (rvalid_a[g]),
      .rdata     (rdata_a[g]),
      .rtag      (rtag_a[g])
    );

    always @(posedge clk) begin
      if (mem_wen_a[g]) mem[mem_addr_a[g]] <= mem_wdata_a[g];
      rd_pipe[1] <= mem[mem_addr_a[g]];
      for (int k = 2; k <= 4; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_rdata_a[g] = rd_pipe[g+1];
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [EW-1:0]     exp_q [NI][$];
  logic [DATA_W-1:0] ref_mem [2**ADDR_W] = '{default: '0};
  logic [1:0]        last_m = 2'd3;
  int                gnt_idx;
  bit                gnt_wr_flag;
  int                ret_count [NI];
  logic [DATA_W-1:0] ret_data  [NI];
  logic [1:0]        ret_tag   [NI];
  bit                cmd_known = 1'b0;
  logic              exp_ren, exp_wen;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_wdata;

  // One clock: sample at negedge, score returns, command and grants, update
  // the reference model, then retire granted requests just after posedge.
  task automatic step();
    logic [3:0]    elig, e_rd, e_wr;
    logic [1:0]    cand;
    logic [EW-1:0] e;
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      if (rvalid_a[g] !== 4'b0000) begin
        ret_count[g]++;
        ret_data[g] = rdata_a[g];
        ret_tag[g]  = rtag_a[g];
        checks++;
        if (exp_q[g].size() == 0) begin
          failures++;
          $display("FAIL unexpected_rvalid lat=%0d cyc=%0d rvalid=%b required=0000", g + 1, cyc, rvalid_a[g]);
        end else begin
          e = exp_q[g].pop_front();
          if (rvalid_a[g] !== (4'b0001 << e[DATA_W +: 2]) || rtag_a[g] !== e[DATA_W +: 2] ||
              rdata_a[g] !== e[DATA_W-1:0] || cyc != int'(e[EW-1 -: 32]) + g + 3) begin
            failures++;
            $display("FAIL read_return lat=%0d cyc=%0d rvalid=%b rtag=%0d rdata=%h required tag=%0d data=%h cyc=%0d",
                     g + 1, cyc, rvalid_a[g], rtag_a[g], rdata_a[g], e[DATA_W +: 2], e[DATA_W-1:0],
                     int'(e[EW-1 -: 32]) + g + 3);
          end
        end
      end
      if (cmd_known) begin
        checks++;
        if (mem_ren_a[g] !== exp_ren || mem_wen_a[g] !== exp_wen ||
            mem_addr_a[g] !== exp_addr || mem_wdata_a[g] !== exp_wdata) begin
          failures++;
          $display("FAIL mem_cmd lat=%0d cyc=%0d ren=%b wen=%b addr=%h wdata=%h required %b %b %h %h",
                   g + 1, cyc, mem_ren_a[g], mem_wen_a[g], mem_addr_a[g], mem_wdata_a[g],
                   exp_ren, exp_wen, exp_addr, exp_wdata);
        end
      end
    end

    elig    = reset ? 4'b0000 : (core_en & (req_rd | req_wr));
    gnt_idx = -1;
    e_rd    = 4'b0000;
    e_wr    = 4'b0000;
    for (int k = 1; k <= 4; k++) begin
      cand = last_m + k[1:0];
      if (gnt_idx < 0 && elig[cand]) gnt_idx = int'(cand);
    end
    if (gnt_idx >= 0) begin
      if (req_wr[gnt_idx]) e_wr[gnt_idx] = 1'b1;
      else                 e_rd[gnt_idx] = 1'b1;
    end
    gnt_wr_flag = |e_wr;
    for (int g = 0; g < NI; g++) begin
      checks++;
      if (gnt_rd_a[g] !== e_rd || gnt_wr_a[g] !== e_wr || stall_a[g] !== (elig & ~e_rd & ~e_wr)) begin
        failures++;
        $display("FAIL grant lat=%0d cyc=%0d gnt_rd=%b gnt_wr=%b stall=%b required %b %b %b",
                 g + 1, cyc, gnt_rd_a[g], gnt_wr_a[g], stall_a[g], e_rd, e_wr, elig & ~e_rd & ~e_wr);
      end
    end

    if (reset) begin
      for (int g = 0; g < NI; g++) exp_q[g].delete();
      last_m    = 2'd3;
      exp_ren   = 1'b0;
      exp_wen   = 1'b0;
      exp_addr  = '0;
      exp_wdata = '0;
      cmd_known = 1'b1;
    end else begin
      exp_ren = |e_rd;
      exp_wen = |e_wr;
      if (gnt_idx >= 0) begin
        last_m    = gnt_idx[1:0];
        exp_addr  = req_addr[gnt_idx*ADDR_W +: ADDR_W];
        exp_wdata = req_wdata[gnt_idx*DATA_W +: DATA_W];
        if (gnt_wr_flag) ref_mem[exp_addr] = exp_wdata;
        else for (int g = 0; g < NI; g++) exp_q[g].push_back({32'(cyc), gnt_idx[1:0], ref_mem[exp_addr]});
      end
    end

    @(posedge clk);
    #1;
    cyc++;
    if (gnt_idx >= 0) begin
      if (gnt_wr_flag) req_wr[gnt_idx] = 1'b0;
      else             req_rd[gnt_idx] = 1'b0;
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int g = 0; g < NI; g++) n += exp_q[g].size();
    return n;
  endfunction

  task automatic drain();
    int n = 0;
    while (pending() != 0 && n < 30) begin
      step();
      n++;
    end
    checks++;
    if (pending() != 0) begin
      failures++;
      $display("FAIL drain_timeout outstanding=%0d required=0", pending());
    end
  endtask

  task automatic set_core(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_addr[i*ADDR_W +: ADDR_W]  = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    core_en   = 4'hF;
    req_rd    = 4'hF;
    req_wr    = 4'h0;
    req_addr  = '0;
    req_wdata = '0;
    step();
    step();
    for (int g = 0; g < NI; g++) begin
      checks++;
      if (mem_ren_a[g] !== 1'b0 || mem_wen_a[g] !== 1'b0 || mem_addr_a[g] !== '0 || mem_wdata_a[g] !== '0 ||
          rvalid_a[g] !== 4'b0000 || rdata_a[g] !== '0 || rtag_a[g] !== 2'd0 || gnt_rd_a[g] !== 4'b0000) begin
        failures++;
        $display("FAIL reset_values lat=%0d ren=%b wen=%b addr=%h wdata=%h rvalid=%b rdata=%h rtag=%0d gnt_rd=%b required all zero",
                 g + 1, mem_ren_a[g], mem_wen_a[g], mem_addr_a[g], mem_wdata_a[g], rvalid_a[g], rdata_a[g],
                 rtag_a[g], gnt_rd_a[g]);
      end
    end
    req_rd = 4'h0;
    reset  = 1'b0;
  endtask

  task automatic test_round_robin();
    int rc0 = ret_count[0];
    for (int i = 0; i < 4; i++) set_core(i, ADDR_W'(16'h10 + i), 16'h0);
    req_rd = 4'hF;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (gnt_idx != k || gnt_wr_flag) begin
        failures++;
        $display("FAIL rr_order step=%0d granted=%0d wr=%0d required core=%0d read", k, gnt_idx, gnt_wr_flag, k);
      end
    end
    drain();
    checks++;
    if (ret_count[0] != rc0 + 4 || ret_tag[0] !== 2'd3) begin
      failures++;
      $display("FAIL rr_returns count=%0d last_tag=%0d required count=%0d last_tag=3", ret_count[0] - rc0, ret_tag[0], 4);
    end
  endtask

  task automatic test_alternate();
    set_core(1, ADDR_W'(16'h40), 16'h0);
    set_core(3, ADDR_W'(16'h41), 16'h0);
    req_rd = 4'b1010;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (gnt_idx != ((k % 2 == 0) ? 1 : 3)) begin
        failures++;
        $display("FAIL alternate step=%0d granted=%0d required=%0d", k, gnt_idx, (k % 2 == 0) ? 1 : 3);
      end
      req_rd = 4'b1010;
    end
    req_rd = 4'b0000;
    drain();
  endtask

  task automatic test_write_read();
    set_core(2, ADDR_W'(16'h20), 16'hBEEF);
    req_wr = 4'b0100;
    req_rd = 4'b0100;
    step();
    checks++;
    if (gnt_idx != 2 || !gnt_wr_flag) begin
      failures++;
      $display("FAIL write_first granted=%0d wr=%0d required core=2 write", gnt_idx, gnt_wr_flag);
    end
    step();
    checks++;
    if (gnt_idx != 2 || gnt_wr_flag) begin
      failures++;
      $display("FAIL read_second granted=%0d wr=%0d required core=2 read", gnt_idx, gnt_wr_flag);
    end
    drain();
    for (int g = 0; g < NI; g++) begin
      checks++;
      if (ret_data[g] !== 16'hBEEF || ret_tag[g] !== 2'd2) begin
        failures++;
        $display("FAIL write_read_data lat=%0d rdata=%h rtag=%0d required BEEF tag=2", g + 1, ret_data[g], ret_tag[g]);
      end
    end
  endtask

  task automatic test_mask();
    int waited = 0;
    bit got = 1'b0;
    for (int i = 0; i < 4; i++) set_core(i, ADDR_W'(16'h50 + i), 16'h0);
    core_en = 4'b1101;
    req_rd  = 4'hF;
    for (int k = 0; k < 12; k++) begin
      step();
      req_rd = 4'hF;
      #1;
      checks++;
      if (gnt_idx == 1 || stall_a[0][1] !== 1'b0) begin
        failures++;
        $display("FAIL masked_core step=%0d granted=%0d stall1=%b required no grant, stall1=0", k, gnt_idx, stall_a[0][1]);
      end
    end
    core_en = 4'hF;
    while (!got && waited < 5) begin
      step();
      if (gnt_idx == 1) got = 1'b1;
      else begin
        waited++;
        req_rd = 4'hF;
      end
    end
    checks++;
    if (!got || waited > 3) begin
      failures++;
      $display("FAIL reenable_wait waited=%0d granted=%0d required wait<=3", waited, got);
    end
    req_rd = 4'h0;
    drain();
  endtask

  task automatic test_reset_mid();
    int rc = 0;
    for (int g = 0; g < NI; g++) rc += ret_count[g];
    set_core(0, ADDR_W'(16'h60), 16'h0);
    set_core(1, ADDR_W'(16'h61), 16'h0);
    req_rd = 4'b0011;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int g = 0; g < NI; g++) begin
      checks++;
      if (mem_ren_a[g] !== 1'b0 || rvalid_a[g] !== 4'b0000) begin
        failures++;
        $display("FAIL reset_mid_cmd lat=%0d mem_ren=%b rvalid=%b required 0 0000", g + 1, mem_ren_a[g], rvalid_a[g]);
      end
    end
    for (int k = 0; k < 8; k++) step();
    for (int g = 0; g < NI; g++) rc -= ret_count[g];
    checks++;
    if (rc != 0) begin
      failures++;
      $display("FAIL reset_drop returns=%0d required=0", -rc);
    end
    req_rd = 4'hF;
    step();
    checks++;
    if (gnt_idx != 0) begin
      failures++;
      $display("FAIL reset_last granted=%0d required=0", gnt_idx);
    end
    req_rd = 4'h0;
    drain();
  endtask

  task automatic test_random_sweep();
    int op;
    int n = 0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 15) == 0) core_en = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
        if (!req_rd[i] && !req_wr[i] && $urandom_range(0, 2) == 0) begin
          op = $urandom_range(0, 3);
          set_core(i, ADDR_W'(32'h30 + $urandom_range(0, 7)), DATA_W'($urandom));
          req_wr[i] = (op == 0 || op == 3);
          req_rd[i] = (op != 0);
        end
      end
      step();
    end
    core_en = 4'hF;
    while ((req_rd | req_wr) != 4'h0 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if ((req_rd | req_wr) != 4'h0) begin
      failures++;
      $display("FAIL random_requests_left req_rd=%b req_wr=%b required 0000", req_rd, req_wr);
    end
    drain();
  endtask

  initial begin
    for (int g = 0; g < NI; g++) begin
      ret_count[g] = 0;
      ret_data[g]  = '0;
      ret_tag[g]   = '0;
    end
    test_reset();
    test_round_robin();
    test_alternate();
    test_write_read();
    test_mask();
    test_reset_mid();
    test_random_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
